// File: rtl/increment_checker_pkg.sv
// Shared definitions for the incrementing-count stream checker.
// Holds the FSM state encoding and the saturating-increment helper.
// Pure declarations: no timing, no flow control.
package increment_checker_pkg;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_SLIP    = 2'd2
    } state_t;

    // Returns val+1, clamped at max_val so a counter never rolls over.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        if (val >= max_val)
            return max_val;
        else
            return val + 32'd1;
    endfunction

endpackage

// File: rtl/increment_checker_sat.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
// Latency: count reflects inc one cycle after the sampling edge.
// No backpressure; inc is an unconditional one-cycle event.
module sat_counter
    import increment_checker_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [31:0] MAX_VAL = 32'((64'd1 << CNT_WIDTH) - 64'd1);

    // Count events, clamping at the maximum value.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc)
            count <= CNT_WIDTH'(sat_inc(32'(count), MAX_VAL));
    end

endmodule

// File: rtl/increment_checker.sv
// Locks onto an incrementing count stream and checks each word against previous+STEP.
// Latency: every output is registered, valid one cycle after the sampling edge.
// No backpressure; samples are taken whenever t_valid is high.
module increment_checker
    import increment_checker_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int STEP        = 1,
    parameter int RESYNC_ERRS = 3,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     t,
    input  logic                 t_valid,
    output logic                 locked,
    output logic [WIDTH-1:0]     expected,
    output logic                 err_pulse,
    output logic                 wrap_pulse,
    output logic                 resync_pulse,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] wrap_count
);

    localparam int              CW     = (RESYNC_ERRS < 2) ? 1 : $clog2(RESYNC_ERRS + 1);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    state_t          state;
    logic [CW-1:0]   consec;

    // Carry out of the WIDTH+1 bit sums is the wrap indicator.
    logic [WIDTH:0]  exp_sum;
    logic [WIDTH:0]  v_sum;
    logic            match;
    logic            err_ev;
    logic            wrap_ev;
    logic            resync_ev;

    // Classify the current sample: mismatch, wrap and forced re-lock events.
    always_comb begin
        exp_sum   = {1'b0, expected} + {1'b0, STEP_W};
        v_sum     = {1'b0, t} + {1'b0, STEP_W};
        match     = (t == expected);
        err_ev    = 1'b0;
        wrap_ev   = 1'b0;
        resync_ev = 1'b0;
        if (t_valid) begin
            case (state)
                ST_ACQUIRE: wrap_ev = v_sum[WIDTH];
                ST_LOCKED, ST_SLIP: begin
                    if (match) begin
                        wrap_ev = exp_sum[WIDTH];
                    end else begin
                        err_ev    = 1'b1;
                        // LOCKED always enters with consec=0, so one rule covers both states.
                        resync_ev = (int'(consec) + 1 >= RESYNC_ERRS);
                    end
                end
                default: ;
            endcase
        end
    end

    // Tracking FSM with registered status and pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_ACQUIRE;
            locked       <= 1'b0;
            expected     <= '0;
            consec       <= '0;
            err_pulse    <= 1'b0;
            wrap_pulse   <= 1'b0;
            resync_pulse <= 1'b0;
        end else begin
            err_pulse    <= err_ev;
            wrap_pulse   <= wrap_ev;
            resync_pulse <= resync_ev;
            if (t_valid) begin
                case (state)
                    ST_ACQUIRE: begin
                        expected <= v_sum[WIDTH-1:0];
                        state    <= ST_LOCKED;
                        locked   <= 1'b1;
                        consec   <= '0;
                    end
                    ST_LOCKED, ST_SLIP: begin
                        if (match) begin
                            expected <= exp_sum[WIDTH-1:0];
                            consec   <= '0;
                            state    <= ST_LOCKED;
                        end else if (resync_ev) begin
                            expected <= v_sum[WIDTH-1:0];
                            consec   <= '0;
                            state    <= ST_LOCKED;
                        end else begin
                            // Expectation free-runs through a slip.
                            expected <= exp_sum[WIDTH-1:0];
                            consec   <= consec + CW'(1);
                            state    <= ST_SLIP;
                        end
                    end
                    default: begin
                        state  <= ST_ACQUIRE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_ev),
        .count (err_count)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wrap_ev),
        .count (wrap_count)
    );

endmodule

// File: tb/tb_increment_checker.sv
// Directed bench for increment_checker: lock, wrap, slip, resync, gaps, reset, saturation.
// Inputs change 1ns after a rising edge; outputs are sampled 1ns after the next edge.
// A second instance with narrow counters and single-error resync covers saturation.
module tb_increment_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] t;
    logic       t_valid;
    logic       locked, err_pulse, wrap_pulse, resync_pulse;
    logic [4:0] expected;
    logic [7:0] err_count, wrap_count;

    logic       reset2;
    logic [4:0] t2;
    logic       t_valid2;
    logic       locked2, err_pulse2, wrap_pulse2, resync_pulse2;
    logic [4:0] expected2;
    logic [1:0] err_count2, wrap_count2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    increment_checker #(.WIDTH(5), .STEP(1), .RESYNC_ERRS(3), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .t(t), .t_valid(t_valid),
        .locked(locked), .expected(expected), .err_pulse(err_pulse),
        .wrap_pulse(wrap_pulse), .resync_pulse(resync_pulse),
        .err_count(err_count), .wrap_count(wrap_count)
    );

    increment_checker #(.WIDTH(5), .STEP(1), .RESYNC_ERRS(1), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset2), .t(t2), .t_valid(t_valid2),
        .locked(locked2), .expected(expected2), .err_pulse(err_pulse2),
        .wrap_pulse(wrap_pulse2), .resync_pulse(resync_pulse2),
        .err_count(err_count2), .wrap_count(wrap_count2)
    );

    // Apply one sample to dut and wait until its registered result is visible.
    task automatic drive(input logic [4:0] v, input logic vld);
        t       = v;
        t_valid = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic [4:0] v, input logic vld);
        t2       = v;
        t_valid2 = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset   = 1'b1;
        t_valid = 1'b0;
        t       = '0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(2);
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got=%b want=0", locked); end
        n_vec++; if (expected !== 5'd0) begin n_err++; $display("FAIL reset_expected got=%0d want=0", expected); end
        n_vec++; if ({err_pulse, wrap_pulse, resync_pulse} !== 3'b000) begin n_err++; $display("FAIL reset_pulses got=%b want=000", {err_pulse, wrap_pulse, resync_pulse}); end
        n_vec++; if (err_count !== 8'd0 || wrap_count !== 8'd0) begin n_err++; $display("FAIL reset_counts got=%0d/%0d want=0/0", err_count, wrap_count); end
    endtask

    task automatic test_lock;
        logic [4:0] vals [4] = '{5'd5, 5'd6, 5'd7, 5'd8};
        for (int i = 0; i < 4; i++) begin
            drive(vals[i], 1'b1);
            n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL lock_locked[%0d] got=%b want=1", i, locked); end
            n_vec++; if (expected !== vals[i] + 5'd1) begin n_err++; $display("FAIL lock_expected[%0d] got=%0d want=%0d", i, expected, vals[i] + 5'd1); end
            n_vec++; if ({err_pulse, wrap_pulse, resync_pulse} !== 3'b000) begin n_err++; $display("FAIL lock_pulses[%0d] got=%b want=000", i, {err_pulse, wrap_pulse, resync_pulse}); end
        end
        n_vec++; if (expected !== 5'd9) begin n_err++; $display("FAIL lock_final_expected got=%0d want=9", expected); end
        n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL lock_err_count got=%0d want=0", err_count); end
    endtask

    task automatic test_wrap;
        logic [4:0] vals [5] = '{5'd29, 5'd30, 5'd31, 5'd0, 5'd1};
        logic [4:0] exps [5] = '{5'd30, 5'd31, 5'd0, 5'd1, 5'd2};
        logic       wraps[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            drive(vals[i], 1'b1);
            n_vec++; if (wrap_pulse !== wraps[i]) begin n_err++; $display("FAIL wrap_pulse[%0d] got=%b want=%b", i, wrap_pulse, wraps[i]); end
            n_vec++; if (expected !== exps[i]) begin n_err++; $display("FAIL wrap_expected[%0d] got=%0d want=%0d", i, expected, exps[i]); end
            n_vec++; if (err_pulse !== 1'b0) begin n_err++; $display("FAIL wrap_err_pulse[%0d] got=%b want=0", i, err_pulse); end
        end
        n_vec++; if (wrap_count !== 8'd1) begin n_err++; $display("FAIL wrap_count got=%0d want=1", wrap_count); end
        n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL wrap_err_count got=%0d want=0", err_count); end
    endtask

    task automatic test_single_err;
        logic [4:0] vals [4] = '{5'd10, 5'd13, 5'd12, 5'd13};
        logic [4:0] exps [4] = '{5'd11, 5'd12, 5'd13, 5'd14};
        logic       errs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        do_reset(1);
        drive(5'd9, 1'b1);
        n_vec++; if (expected !== 5'd10) begin n_err++; $display("FAIL slip_setup got=%0d want=10", expected); end
        for (int i = 0; i < 4; i++) begin
            drive(vals[i], 1'b1);
            n_vec++; if (err_pulse !== errs[i]) begin n_err++; $display("FAIL slip_err_pulse[%0d] got=%b want=%b", i, err_pulse, errs[i]); end
            n_vec++; if (expected !== exps[i]) begin n_err++; $display("FAIL slip_expected[%0d] got=%0d want=%0d", i, expected, exps[i]); end
            n_vec++; if (resync_pulse !== 1'b0 || locked !== 1'b1) begin n_err++; $display("FAIL slip_resync_locked[%0d] got=%b%b want=01", i, resync_pulse, locked); end
        end
        n_vec++; if (err_count !== 8'd1) begin n_err++; $display("FAIL slip_err_count got=%0d want=1", err_count); end
    endtask

    task automatic test_resync;
        logic [4:0] vals [4] = '{5'd20, 5'd21, 5'd22, 5'd23};
        logic [4:0] exps [4] = '{5'd5, 5'd6, 5'd23, 5'd24};
        logic       errs [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic       rsyn [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_reset(1);
        drive(5'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(vals[i], 1'b1);
            n_vec++; if (err_pulse !== errs[i]) begin n_err++; $display("FAIL resync_err_pulse[%0d] got=%b want=%b", i, err_pulse, errs[i]); end
            n_vec++; if (resync_pulse !== rsyn[i]) begin n_err++; $display("FAIL resync_pulse[%0d] got=%b want=%b", i, resync_pulse, rsyn[i]); end
            n_vec++; if (expected !== exps[i]) begin n_err++; $display("FAIL resync_expected[%0d] got=%0d want=%0d", i, expected, exps[i]); end
        end
        n_vec++; if (err_count !== 8'd3) begin n_err++; $display("FAIL resync_err_count got=%0d want=3", err_count); end
    endtask

    task automatic test_gaps_and_reset;
        do_reset(1);
        drive(5'd2, 1'b1);
        drive(5'd3, 1'b1);
        drive(5'd17, 1'b0);
        n_vec++; if (expected !== 5'd4 || err_pulse !== 1'b0) begin n_err++; $display("FAIL gap1 got=%0d/%b want=4/0", expected, err_pulse); end
        drive(5'd17, 1'b0);
        n_vec++; if (expected !== 5'd4 || err_pulse !== 1'b0) begin n_err++; $display("FAIL gap2 got=%0d/%b want=4/0", expected, err_pulse); end
        drive(5'd4, 1'b1);
        n_vec++; if (expected !== 5'd5 || err_pulse !== 1'b0) begin n_err++; $display("FAIL gap_resume got=%0d/%b want=5/0", expected, err_pulse); end
        drive(5'd9, 1'b1);
        n_vec++; if (err_count !== 8'd1 || err_pulse !== 1'b1) begin n_err++; $display("FAIL gap_enter_slip got=%0d/%b want=1/1", err_count, err_pulse); end
        // Reset together with a matching sample: reset must win.
        reset = 1'b1;
        drive(5'd6, 1'b1);
        reset = 1'b0;
        n_vec++; if (locked !== 1'b0 || expected !== 5'd0) begin n_err++; $display("FAIL midreset_state got=%b/%0d want=0/0", locked, expected); end
        n_vec++; if (err_count !== 8'd0 || wrap_count !== 8'd0 || err_pulse !== 1'b0) begin n_err++; $display("FAIL midreset_counts got=%0d/%0d/%b want=0/0/0", err_count, wrap_count, err_pulse); end
        drive(5'd7, 1'b1);
        n_vec++; if (locked !== 1'b1 || expected !== 5'd8 || err_pulse !== 1'b0) begin n_err++; $display("FAIL midreset_reacquire got=%b/%0d/%b want=1/8/0", locked, expected, err_pulse); end
        t_valid = 1'b0;
    endtask

    task automatic test_saturation;
        reset2 = 1'b1;
        drive2(5'd0, 1'b0);
        reset2 = 1'b0;
        drive2(5'd0, 1'b0);
        n_vec++; if (err_count2 !== 2'd0 || locked2 !== 1'b0) begin n_err++; $display("FAIL sat_reset got=%0d/%b want=0/0", err_count2, locked2); end
        drive2(5'd0, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            drive2(5'd10, 1'b1);
            n_vec++; if (err_count2 !== ((i > 3) ? 2'd3 : 2'(i))) begin n_err++; $display("FAIL sat_err_count[%0d] got=%0d want=%0d", i, err_count2, (i > 3) ? 3 : i); end
            n_vec++; if (err_pulse2 !== 1'b1 || resync_pulse2 !== 1'b1) begin n_err++; $display("FAIL sat_err_resync[%0d] got=%b%b want=11", i, err_pulse2, resync_pulse2); end
            n_vec++; if (expected2 !== 5'd11) begin n_err++; $display("FAIL sat_expected[%0d] got=%0d want=11", i, expected2); end
        end
        reset2 = 1'b1;
        drive2(5'd0, 1'b0);
        reset2 = 1'b0;
        drive2(5'd31, 1'b1);
        n_vec++; if (wrap_count2 !== 2'd1 || wrap_pulse2 !== 1'b1 || expected2 !== 5'd0) begin n_err++; $display("FAIL sat_wrap_acq got=%0d/%b/%0d want=1/1/0", wrap_count2, wrap_pulse2, expected2); end
        for (int i = 2; i <= 5; i++) begin
            drive2(5'd30, 1'b1);
            n_vec++; if (wrap_pulse2 !== 1'b0 || expected2 !== 5'd31) begin n_err++; $display("FAIL sat_wrap_setup[%0d] got=%b/%0d want=0/31", i, wrap_pulse2, expected2); end
            drive2(5'd31, 1'b1);
            n_vec++; if (wrap_pulse2 !== 1'b1 || err_pulse2 !== 1'b0) begin n_err++; $display("FAIL sat_wrap_pulse[%0d] got=%b/%b want=1/0", i, wrap_pulse2, err_pulse2); end
            n_vec++; if (wrap_count2 !== ((i > 3) ? 2'd3 : 2'(i))) begin n_err++; $display("FAIL sat_wrap_count[%0d] got=%0d want=%0d", i, wrap_count2, (i > 3) ? 3 : i); end
        end
        t_valid2 = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        t        = '0;
        t_valid  = 1'b0;
        reset2   = 1'b1;
        t2       = '0;
        t_valid2 = 1'b0;
        test_reset();
        test_lock();
        test_wrap();
        test_single_err();
        test_resync();
        test_gaps_and_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
